// File: rtl/seg_scan_capture.sv
// Rebuilds the eight digit bytes of a multiplexed seven-segment scan and publishes complete frames.
// Latency: frame strobe one cycle after the sample that fills the last digit; no backpressure.
module seg_scan_capture #(
  parameter bit          COM_ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE         = 2,
  parameter int unsigned STABLE_N       = 3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  i_com,
  input  logic [7:0]  i_ens,
  output logic [63:0] o_frame,
  output logic        o_frame_stb,
  output logic        o_frame_valid,
  output logic        o_changed,
  output logic        o_stable,
  output logic        o_err
);

  typedef enum logic [1:0] {EMPTY, FILLING, PUBLISH} state_t;

  localparam logic [3:0] SETTLE_W   = 4'(SETTLE);
  localparam logic [3:0] STABLE_W   = 4'(STABLE_N);
  localparam logic [7:0] COM_IDLE   = COM_ACTIVE_LOW ? 8'hFF : 8'h00;

  state_t      state, state_nxt;
  logic [7:0]  r_com, r_ens, c, prev_c, mask, mask_nxt;
  logic [3:0]  dwell_q, dwell_cur, stab_cnt, stab_nxt;
  logic [63:0] shadow, shadow_nxt;
  logic [2:0]  sel_idx;
  logic        is_idle, is_sel, is_ill, c_moved, sample, complete, pub_changed;

  always_comb begin
    c       = COM_ACTIVE_LOW ? ~r_com : r_com;
    is_idle = (c == 8'd0);
    is_sel  = !is_idle && ((c & (c - 8'd1)) == 8'd0);
    is_ill  = !is_idle && !is_sel;
    c_moved = (c != prev_c);
    sel_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (c[k]) sel_idx = 3'(k);
    end

    if (!is_sel)               dwell_cur = 4'd0;
    else if (c_moved)          dwell_cur = 4'd1;
    else if (dwell_q == 4'hF)  dwell_cur = 4'hF;
    else                       dwell_cur = dwell_q + 4'd1;

    // The second term stops a saturated dwell from resampling every cycle.
    sample   = is_sel && (dwell_cur == SETTLE_W) && (c_moved || dwell_q != SETTLE_W);
    complete = sample && ((mask | c) == 8'hFF);

    shadow_nxt = shadow;
    if (sample) shadow_nxt[{sel_idx, 3'b000} +: 8] = r_ens;

    if (is_ill || complete) mask_nxt = 8'd0;
    else if (sample)        mask_nxt = mask | c;
    else                    mask_nxt = mask;

    pub_changed = !o_frame_valid || (shadow_nxt != o_frame);
    if (pub_changed)            stab_nxt = 4'd1;
    else if (stab_cnt == 4'hF)  stab_nxt = 4'hF;
    else                        stab_nxt = stab_cnt + 4'd1;
  end

  always_comb begin
    state_nxt   = state;
    o_frame_stb = (state == PUBLISH);
    case (state)
      EMPTY:   if (complete) state_nxt = PUBLISH;
               else if (sample || is_ill) state_nxt = FILLING;
      FILLING: if (complete) state_nxt = PUBLISH;
      PUBLISH: state_nxt = complete ? PUBLISH : FILLING;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= EMPTY;
      r_com         <= COM_IDLE;
      r_ens         <= 8'd0;
      prev_c        <= 8'd0;
      dwell_q       <= 4'd0;
      mask          <= 8'd0;
      shadow        <= 64'd0;
      stab_cnt      <= 4'd0;
      o_frame       <= 64'd0;
      o_frame_valid <= 1'b0;
      o_changed     <= 1'b0;
      o_stable      <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      state     <= state_nxt;
      r_com     <= i_com;
      r_ens     <= i_ens;
      prev_c    <= c;
      dwell_q   <= dwell_cur;
      mask      <= mask_nxt;
      shadow    <= shadow_nxt;
      o_err     <= is_ill;
      o_changed <= complete && pub_changed;
      if (complete) begin
        o_frame       <= shadow_nxt;
        o_frame_valid <= 1'b1;
        stab_cnt      <= stab_nxt;
        o_stable      <= (stab_nxt >= STABLE_W);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed scan sequences; expected frames queued at drive time and matched on each strobe.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  i_com, i_ens;
  logic [63:0] o_frame;
  logic        o_frame_stb, o_frame_valid, o_changed, o_stable, o_err;

  typedef struct packed {
    logic [63:0] f;
    logic        ch;
    logic        st;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   stb_cnt = 0;
  int   err_cnt = 0;
  int   snap;

  localparam logic [63:0] F1 = 64'h1716151413121110;
  localparam logic [63:0] F2 = 64'h1716151433121110;
  localparam logic [63:0] F3 = 64'h1716151413121111;

  seg_scan_capture #(.COM_ACTIVE_LOW(1'b1), .SETTLE(2), .STABLE_N(3)) dut (
    .clk(clk), .nrst(nrst), .i_com(i_com), .i_ens(i_ens),
    .o_frame(o_frame), .o_frame_stb(o_frame_stb), .o_frame_valid(o_frame_valid),
    .o_changed(o_changed), .o_stable(o_stable), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_pub(input logic [63:0] f, input logic ch, input logic st);
    exp_t e;
    e.f = f; e.ch = ch; e.st = st;
    q.push_back(e);
  endtask

  task automatic dig(input int d, input logic [7:0] e, input int n);
    logic [7:0] one;
    one   = 8'h01;
    i_com = ~(one << d);
    i_ens = e;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_com = 8'hFF;
    i_ens = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [63:0] f);
    for (int d = 0; d < 8; d++) dig(d, f[8*d +: 8], 4);
  endtask

  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      if (o_err) err_cnt++;
      if (o_frame_stb) begin
        exp_t e;
        stb_cnt++;
        if (q.size() == 0) begin
          check("unexpected_stb", 64'(o_frame_stb), 64'd0);
        end else begin
          e = q.pop_front();
          check("frame",  o_frame, e.f);
          check("changed", 64'(o_changed), 64'(e.ch));
          check("stable",  64'(o_stable),  64'(e.st));
          check("valid",   64'(o_frame_valid), 64'd1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst  = 1'b0;
    i_com = 8'hFF;
    i_ens = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_frame",   o_frame, 64'd0);
    check("rst_stb",     64'(o_frame_stb), 64'd0);
    check("rst_valid",   64'(o_frame_valid), 64'd0);
    check("rst_changed", 64'(o_changed), 64'd0);
    check("rst_stable",  64'(o_stable), 64'd0);
    check("rst_err",     64'(o_err), 64'd0);
    nrst = 1'b1;
    idle(3);
    check("idle_no_err", 64'(err_cnt), 64'd0);

    // single frame
    snap = stb_cnt;
    expect_pub(F1, 1'b1, 1'b0);
    scan(F1);
    idle(3);
    check("t1_stb_count", 64'(stb_cnt - snap), 64'd1);

    // short dwell on digit 3 is ignored until held long enough
    snap = stb_cnt;
    for (int d = 0; d < 3; d++) dig(d, F1[8*d +: 8], 4);
    dig(3, 8'hAA, 1);
    for (int d = 4; d < 8; d++) dig(d, F1[8*d +: 8], 4);
    idle(3);
    check("t2_no_pub", 64'(stb_cnt - snap), 64'd0);
    expect_pub(F2, 1'b1, 1'b0);
    dig(3, 8'h33, 2);
    idle(3);
    check("t2_pub", 64'(stb_cnt - snap), 64'd1);

    // illegal COM clears the mask
    snap = stb_cnt;
    for (int d = 0; d < 4; d++) dig(d, F1[8*d +: 8], 4);
    i_com = 8'hFC;
    @(negedge clk);
    for (int d = 4; d < 8; d++) dig(d, F1[8*d +: 8], 4);
    idle(3);
    check("t3_err_count", 64'(err_cnt), 64'd1);
    check("t3_no_pub", 64'(stb_cnt - snap), 64'd0);
    for (int d = 0; d < 3; d++) dig(d, F1[8*d +: 8], 4);
    idle(3);
    check("t3_still_no_pub", 64'(stb_cnt - snap), 64'd0);
    expect_pub(F1, 1'b1, 1'b0);
    dig(3, F1[31:24], 4);
    idle(3);
    check("t3_pub", 64'(stb_cnt - snap), 64'd1);

    // stability over repeated identical frames, then a one-bit change
    expect_pub(F1, 1'b0, 1'b0);
    scan(F1);
    expect_pub(F1, 1'b0, 1'b1);
    scan(F1);
    expect_pub(F1, 1'b0, 1'b1);
    scan(F1);
    expect_pub(F3, 1'b1, 1'b0);
    scan(F3);
    idle(3);
    check("t4_queue_drained", 64'(q.size()), 64'd0);

    // reset in the middle of a frame
    for (int d = 0; d < 5; d++) dig(d, F1[8*d +: 8], 4);
    nrst = 1'b0;
    #1;
    check("t5_frame",   o_frame, 64'd0);
    check("t5_valid",   64'(o_frame_valid), 64'd0);
    check("t5_stable",  64'(o_stable), 64'd0);
    check("t5_changed", 64'(o_changed), 64'd0);
    i_com = 8'hFF;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    idle(2);
    snap = stb_cnt;
    for (int d = 0; d < 7; d++) dig(d, F1[8*d +: 8], 4);
    idle(3);
    check("t5_no_pub", 64'(stb_cnt - snap), 64'd0);
    expect_pub(F1, 1'b1, 1'b0);
    dig(7, F1[63:56], 4);
    idle(3);
    check("t5_pub", 64'(stb_cnt - snap), 64'd1);

    // reverse scan order with blanking gaps
    snap = stb_cnt;
    expect_pub(F1, 1'b0, 1'b0);
    for (int d = 7; d >= 0; d--) begin
      dig(d, F1[8*d +: 8], 4);
      idle(3);
    end
    idle(3);
    check("t6_pub", 64'(stb_cnt - snap), 64'd1);
    check("t6_no_err", 64'(err_cnt), 64'd1);
    check("end_queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
